// File: rtl/cone_delay_chain.sv
// Multi-channel register delay chain with pass / hold / sticky-OR accumulate modes,
// a per-stage valid shadow and a fill/flush occupancy FSM.
module cone_delay_chain #(
  parameter  int CHANNELS = 4,
  parameter  int WIDTH    = 8,
  parameter  int DEPTH    = 3,
  localparam int CNT_W    = $clog2(DEPTH + 1),
  localparam int DW       = CHANNELS * WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [DW-1:0]    in_data,
  input  logic [1:0]       mode,
  input  logic             flush,
  output logic [DW-1:0]    out_data,
  output logic             out_valid,
  output logic             out_or,
  output logic [CNT_W-1:0] fill_count,
  output logic             busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_FULL  = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;

  // Stage s occupies bits [s*DW +: DW]; stage 0 is the input end.
  localparam int TW   = DEPTH * DW;
  localparam int LAST = (DEPTH - 1) * DW;

  logic [TW-1:0]    data_r;
  logic [TW-1:0]    data_nxt_s;
  logic [DEPTH-1:0] v_r;
  logic [DEPTH-1:0] v_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  state_t           state_r;
  state_t           state_nxt_s;
  logic             hold_s;
  logic             acc_s;
  logic             flushing_s;

  function automatic logic [CNT_W-1:0] popcount(input logic [DEPTH-1:0] vec);
    logic [DEPTH-1:0] rem;
    logic [CNT_W-1:0] sum;
    rem = vec;
    sum = '0;
    for (int i = 0; i < DEPTH; i++) begin
      sum = sum + CNT_W'(rem[0]);
      rem = rem >> 1'b1;
    end
    return sum;
  endfunction

  // Mode decode; the reserved encoding behaves as HOLD.
  always_comb begin
    hold_s = 1'b0;
    acc_s  = 1'b0;
    case (mode)
      2'b00:   begin hold_s = 1'b0; acc_s = 1'b0; end
      2'b01:   hold_s = 1'b1;
      2'b10:   acc_s  = 1'b1;
      2'b11:   hold_s = 1'b1;
      default: hold_s = 1'b1;
    endcase
  end

  // A flush request acts on the edge it is sampled, so the coincident input is dropped.
  assign flushing_s = flush | (state_r == ST_FLUSH);

  // Next stage contents: flush shifts in empties, hold freezes, pass/acc shift in the input.
  always_comb begin
    data_nxt_s = data_r;
    v_nxt_s    = v_r;
    if (flushing_s) begin
      data_nxt_s = data_r << DW;
      v_nxt_s    = v_r << 1'b1;
    end else if (hold_s) begin
      data_nxt_s = data_r;
      v_nxt_s    = v_r;
    end else begin
      data_nxt_s = (data_r << DW) | TW'(in_data);
      v_nxt_s    = (v_r << 1'b1) | DEPTH'(in_valid);
      data_nxt_s[LAST +: DW] = data_nxt_s[LAST +: DW] | (acc_s ? data_r[LAST +: DW] : {DW{1'b0}});
      v_nxt_s[DEPTH-1]       = v_nxt_s[DEPTH-1] | (acc_s & v_r[DEPTH-1]);
    end
  end

  assign cnt_nxt_s = popcount(v_nxt_s);

  // Occupancy FSM, steered by the occupancy that the coming edge will produce.
  always_comb begin
    state_nxt_s = state_r;
    if (flush) begin
      state_nxt_s = ST_FLUSH;
    end else if (state_r == ST_FLUSH) begin
      state_nxt_s = (cnt_nxt_s == {CNT_W{1'b0}}) ? ST_IDLE : ST_FLUSH;
    end else if (hold_s) begin
      state_nxt_s = state_r;
    end else if (cnt_nxt_s == {CNT_W{1'b0}}) begin
      state_nxt_s = ST_IDLE;
    end else if (cnt_nxt_s == CNT_W'(DEPTH)) begin
      state_nxt_s = ST_FULL;
    end else begin
      state_nxt_s = ST_FILL;
    end
  end

  // State registers: chain data, valid shadow, occupancy count and FSM state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_r  <= '0;
      v_r     <= '0;
      cnt_r   <= '0;
      state_r <= ST_IDLE;
    end else begin
      data_r  <= data_nxt_s;
      v_r     <= v_nxt_s;
      cnt_r   <= cnt_nxt_s;
      state_r <= state_nxt_s;
    end
  end

  assign out_data   = data_r[LAST +: DW];
  assign out_valid  = v_r[DEPTH-1];
  assign out_or     = v_r[DEPTH-1] & (|data_r[LAST +: DW]);
  assign fill_count = cnt_r;
  assign busy       = (state_r != ST_IDLE);

endmodule

// File: tb/tb_cone_delay_chain.sv
// Scoreboard bench for cone_delay_chain: default configuration plus a 1x1x1 instance.
module tb_cone_delay_chain;

  localparam logic [1:0] P = 2'b00;
  localparam logic [1:0] H = 2'b01;
  localparam logic [1:0] R = 2'b11;
  localparam logic [1:0] A = 2'b10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid, flush, out_valid, out_or, busy;
  logic [31:0] in_data, out_data;
  logic [1:0]  mode, fill_count;

  logic        in_valid1, flush1, out_valid1, out_or1, busy1;
  logic [0:0]  in_data1, out_data1, fill_count1;
  logic [1:0]  mode1;

  typedef struct {
    int          due;
    int          tnum;
    logic        ov;
    logic [31:0] od;
    logic        oor;
    logic [1:0]  fc;
    logic        bz;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   tnum = 0;

  cone_delay_chain dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .mode(mode),
    .flush(flush), .out_data(out_data), .out_valid(out_valid), .out_or(out_or),
    .fill_count(fill_count), .busy(busy)
  );

  cone_delay_chain #(.CHANNELS(1), .WIDTH(1), .DEPTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_data(in_data1), .mode(mode1),
    .flush(flush1), .out_data(out_data1), .out_valid(out_valid1), .out_or(out_or1),
    .fill_count(fill_count1), .busy(busy1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    if (q0.size() > 0 && q0[0].due == cyc) begin
      e = q0.pop_front();
      total++;
      if (out_valid !== e.ov || out_data !== e.od || out_or !== e.oor ||
          fill_count !== e.fc || busy !== e.bz) begin
        bad++;
        $display("FAIL main_t%0d cyc%0d: got v=%b d=%h or=%b cnt=%0d busy=%b want v=%b d=%h or=%b cnt=%0d busy=%b",
                 e.tnum, cyc, out_valid, out_data, out_or, fill_count, busy,
                 e.ov, e.od, e.oor, e.fc, e.bz);
      end
    end
    if (q1.size() > 0 && q1[0].due == cyc) begin
      e = q1.pop_front();
      total++;
      if (out_valid1 !== e.ov || {31'd0, out_data1} !== e.od || out_or1 !== e.oor ||
          {1'b0, fill_count1} !== e.fc || busy1 !== e.bz) begin
        bad++;
        $display("FAIL d1_t%0d cyc%0d: got v=%b d=%h or=%b cnt=%0d busy=%b want v=%b d=%h or=%b cnt=%0d busy=%b",
                 e.tnum, cyc, out_valid1, out_data1, out_or1, fill_count1, busy1,
                 e.ov, e.od, e.oor, e.fc, e.bz);
      end
    end
  end

  task automatic step0(input logic v, input logic [31:0] d, input logic [1:0] m, input logic f,
                       input logic eov, input logic [31:0] eod, input logic [1:0] efc, input logic ebz);
    exp_t e;
    in_valid = v; in_data = d; mode = m; flush = f;
    e.due = cyc + 1; e.tnum = tnum; e.ov = eov; e.od = eod;
    e.oor = eov & (|eod); e.fc = efc; e.bz = ebz;
    q0.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic step1(input logic v, input logic d, input logic [1:0] m, input logic f,
                       input logic eov, input logic eod, input logic efc, input logic ebz);
    exp_t e;
    in_valid1 = v; in_data1 = d; mode1 = m; flush1 = f;
    e.due = cyc + 1; e.tnum = tnum; e.ov = eov; e.od = {31'd0, eod};
    e.oor = eov & eod; e.fc = {1'b0, efc}; e.bz = ebz;
    q1.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    in_valid = 1'b0; in_data = 32'd0; mode = P; flush = 1'b0;
    in_valid1 = 1'b0; in_data1 = 1'b0; mode1 = P; flush1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_fill_count", {30'd0, fill_count}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;

    // latency: one sample, visible three cycles later for one cycle
    tnum = 2;
    step0(1'b1, 32'h5A, P, 1'b0, 1'b0, 32'h0,  2'd1, 1'b1);
    step0(1'b0, 32'h0,  P, 1'b0, 1'b0, 32'h0,  2'd1, 1'b1);
    step0(1'b0, 32'h0,  P, 1'b0, 1'b1, 32'h5A, 2'd1, 1'b1);
    step0(1'b0, 32'h0,  P, 1'b0, 1'b0, 32'h0,  2'd0, 1'b0);

    // fill, hold (both hold encodings) with input active, then overflow in FULL
    tnum = 3;
    step0(1'b1, 32'h11, P, 1'b0, 1'b0, 32'h0,  2'd1, 1'b1);
    step0(1'b1, 32'h22, P, 1'b0, 1'b0, 32'h0,  2'd2, 1'b1);
    step0(1'b1, 32'h33, P, 1'b0, 1'b1, 32'h11, 2'd3, 1'b1);
    for (int i = 0; i < 10; i++)
      step0(1'b1, 32'hFF, (i < 5) ? H : R, 1'b0, 1'b1, 32'h11, 2'd3, 1'b1);
    step0(1'b1, 32'h44, P, 1'b0, 1'b1, 32'h22, 2'd3, 1'b1);

    // flush from FULL with a coincident sample; inputs during FLUSH are ignored
    tnum = 5;
    step0(1'b1, 32'h99, P, 1'b1, 1'b1, 32'h33, 2'd2, 1'b1);
    step0(1'b1, 32'h66, P, 1'b0, 1'b1, 32'h44, 2'd1, 1'b1);
    step0(1'b1, 32'h55, P, 1'b0, 1'b0, 32'h0,  2'd0, 1'b0);
    step0(1'b0, 32'h0,  P, 1'b0, 1'b0, 32'h0,  2'd0, 1'b0);
    step0(1'b1, 32'h77, P, 1'b1, 1'b0, 32'h0,  2'd0, 1'b1);
    step0(1'b0, 32'h0,  P, 1'b0, 1'b0, 32'h0,  2'd0, 1'b0);

    // sticky-OR accumulate on channel 1, then PASS drains it
    tnum = 4;
    step0(1'b1, 32'h0100, A, 1'b0, 1'b0, 32'h0,    2'd1, 1'b1);
    step0(1'b1, 32'h0200, A, 1'b0, 1'b0, 32'h0,    2'd2, 1'b1);
    step0(1'b1, 32'h0400, A, 1'b0, 1'b1, 32'h0100, 2'd3, 1'b1);
    step0(1'b1, 32'h8000, A, 1'b0, 1'b1, 32'h0300, 2'd3, 1'b1);
    step0(1'b0, 32'h0,    A, 1'b0, 1'b1, 32'h0700, 2'd2, 1'b1);
    step0(1'b0, 32'h0,    A, 1'b0, 1'b1, 32'h8700, 2'd1, 1'b1);
    step0(1'b0, 32'h0,    A, 1'b0, 1'b1, 32'h8700, 2'd1, 1'b1);
    step0(1'b0, 32'h0,    A, 1'b0, 1'b1, 32'h8700, 2'd1, 1'b1);
    step0(1'b0, 32'h0,    P, 1'b0, 1'b0, 32'h0,    2'd0, 1'b0);

    // single-stage, single-bit configuration
    tnum = 6;
    step1(1'b1, 1'b1, P, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    step1(1'b0, 1'b0, P, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step1(1'b1, 1'b1, A, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    step1(1'b0, 1'b0, A, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    step1(1'b1, 1'b0, A, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    step1(1'b0, 1'b0, P, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step1(1'b1, 1'b0, A, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    step1(1'b0, 1'b0, P, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step1(1'b0, 1'b0, P, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // asynchronous reset mid-cycle while FULL
    tnum = 1;
    step0(1'b1, 32'hA1B2C3D4, P, 1'b0, 1'b0, 32'h0,        2'd1, 1'b1);
    step0(1'b1, 32'h01020304, P, 1'b0, 1'b0, 32'h0,        2'd2, 1'b1);
    step0(1'b1, 32'hF0E0D0C0, P, 1'b0, 1'b1, 32'hA1B2C3D4, 2'd3, 1'b1);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_out_data", out_data, 32'd0);
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_out_or", {31'd0, out_or}, 32'd0);
    chk("arst_fill_count", {30'd0, fill_count}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);

    repeat (2) @(posedge clk);
    #1;
    chk("scoreboard_drained", q0.size() + q1.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
